// File: rtl/trigger_capture.sv
// Pre/post-trigger sample capture into a ring buffer, with a
// read/ready handshake that hands the frame to an external copier.
// The frame is presented time-ordered on data_o and holds still until
// the copy completes.
module trigger_capture #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned WIDTH   = 12,
   parameter int unsigned PRETRIG = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sample_i,
   input  logic             sample_valid_i,
   input  logic [WIDTH-1:0] trig_level_i,
   input  logic             trig_slope_i,
   input  logic             arm_i,
   input  logic             ready_i,
   output logic             read_o,
   output logic [WIDTH-1:0] data_o [DEPTH],
   output logic             busy_o,
   output logic             triggered_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   localparam logic [CW-1:0] PreCnt   = CW'(PRETRIG);
   localparam logic [CW-1:0] PostCnt  = CW'(DEPTH - PRETRIG - 1);
   localparam logic [AW-1:0] LastPtr  = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PreOfs   = AW'(PRETRIG);
   localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StArmed,
      StPost,
      StHandoff,
      StWaitLow,
      StWaitHigh
   } state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    trig_ptr_q, trig_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             prev_vld_q, prev_vld_d;
   logic             trig_q, trig_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             wr_en;
   logic             trig_hit;
   logic [AW-1:0]    wr_ptr_inc;
   logic [AW-1:0]    start_ptr;

   assign wr_ptr_inc = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + AW'(1);

   // Edge detect against the previous valid sample; never fires without one.
   always_comb begin
      trig_hit = 1'b0;
      if (prev_vld_q) begin
         if (trig_slope_i) begin
            trig_hit = (prev_q < trig_level_i) && (sample_i >= trig_level_i);
         end else begin
            trig_hit = (prev_q > trig_level_i) && (sample_i <= trig_level_i);
         end
      end
   end

   // Next-state logic, buffer write enable and the copy request.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      trig_ptr_d = trig_ptr_q;
      cnt_d      = cnt_q;
      prev_d     = prev_q;
      prev_vld_d = prev_vld_q;
      trig_d     = trig_q;
      wr_en      = 1'b0;
      read_o     = 1'b0;

      unique case (state_q)
         StIdle: begin
            prev_vld_d = 1'b0;
            trig_d     = 1'b0;
            if (arm_i) begin
               wr_ptr_d = '0;
               cnt_d    = '0;
               state_d  = (PRETRIG == 0) ? StArmed : StPre;
            end
         end

         StPre: begin
            if (sample_valid_i) begin
               wr_en      = 1'b1;
               wr_ptr_d   = wr_ptr_inc;
               cnt_d      = cnt_q + CW'(1);
               prev_d     = sample_i;
               prev_vld_d = 1'b1;
               if (cnt_q + CW'(1) == PreCnt) begin
                  state_d = StArmed;
               end
            end
         end

         StArmed: begin
            if (sample_valid_i) begin
               wr_en      = 1'b1;
               wr_ptr_d   = wr_ptr_inc;
               prev_d     = sample_i;
               prev_vld_d = 1'b1;
               if (trig_hit) begin
                  trig_ptr_d = wr_ptr_q;
                  trig_d     = 1'b1;
                  cnt_d      = '0;
                  state_d    = (PostCnt == '0) ? StHandoff : StPost;
               end
            end
         end

         StPost: begin
            if (sample_valid_i) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_inc;
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q + CW'(1) == PostCnt) begin
                  state_d = StHandoff;
               end
            end
         end

         StHandoff: begin
            if (ready_i) begin
               read_o  = 1'b1;
               state_d = StWaitLow;
            end
         end

         StWaitLow: begin
            if (!ready_i) begin
               state_d = StWaitHigh;
            end
         end

         StWaitHigh: begin
            if (ready_i) begin
               trig_d  = 1'b0;
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control state register with synchronous abort on rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         trig_ptr_q <= '0;
         cnt_q      <= '0;
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         trig_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         trig_ptr_q <= trig_ptr_d;
         cnt_q      <= cnt_d;
         prev_q     <= prev_d;
         prev_vld_q <= prev_vld_d;
         trig_q     <= trig_d;
      end
   end

   // Sample ring; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[wr_ptr_q] <= sample_i;
      end
   end

   // Oldest frame entry sits PRETRIG slots behind the trigger, modulo DEPTH.
   assign start_ptr = (trig_ptr_q >= PreOfs) ? (trig_ptr_q - PreOfs) :
                      AW'(CW'(trig_ptr_q) + DepthCnt - CW'(PRETRIG));

   for (genvar g = 0; g < DEPTH; g++) begin : g_out
      logic [CW-1:0] sum;
      logic [AW-1:0] idx;
      assign sum       = CW'(start_ptr) + CW'(g);
      assign idx       = (sum >= DepthCnt) ? AW'(sum - DepthCnt) : sum[AW-1:0];
      assign data_o[g] = mem_q[idx];
   end

   assign busy_o      = (state_q != StIdle);
   assign triggered_o = trig_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Scoreboard bench for trigger_capture: each capture pushes its expected
// frame description; a monitor checks the frame whenever read is pulsed.
module tb_trigger_capture;

   localparam int DEPTH   = 256;
   localparam int WIDTH   = 12;
   localparam int PRETRIG = 64;
   localparam int KRamp   = 0;
   localparam int KSine   = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] sample;
   logic             sample_valid;
   logic [WIDTH-1:0] trig_level;
   logic             trig_slope;
   logic             arm;
   logic             ready;
   logic             read_o;
   logic [WIDTH-1:0] data [DEPTH];
   logic             busy;
   logic             triggered;

   trigger_capture #(
      .DEPTH   (DEPTH),
      .WIDTH   (WIDTH),
      .PRETRIG (PRETRIG)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .sample_i       (sample),
      .sample_valid_i (sample_valid),
      .trig_level_i   (trig_level),
      .trig_slope_i   (trig_slope),
      .arm_i          (arm),
      .ready_i        (ready),
      .read_o         (read_o),
      .data_o         (data),
      .busy_o         (busy),
      .triggered_o    (triggered)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int n0;
      int a0;
      int apre;
      int alast;
   } exp_t;

   exp_t             exp_q [$];
   exp_t             mon_e;
   int               mon_bad;
   int               checks   = 0;
   int               failures = 0;
   int               read_cnt = 0;
   logic [WIDTH-1:0] snap [DEPTH];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int sinv(input int n);
      real x;
      int  r;
      x = 2047.5 + 2047.5 * $sin(2.0 * 3.14159265358979 * n / 100.0);
      r = $rtoi(x + 0.5);
      if (r < 0) r = 0;
      if (r > 4095) r = 4095;
      return r;
   endfunction

   function automatic int val(input int kind, input int n);
      if (kind == KSine) return sinv(n);
      return n;
   endfunction

   task automatic push_exp(input int kind, input int n0, input int a0, input int apre,
                           input int alast);
      exp_t e;
      e.kind  = kind;
      e.n0    = n0;
      e.a0    = a0;
      e.apre  = apre;
      e.alast = alast;
      exp_q.push_back(e);
   endtask

   // Monitor: on every read pulse, snapshot the frame and score it.
   always @(negedge clk) begin
      if (read_o === 1'b1) begin
         read_cnt++;
         for (int i = 0; i < DEPTH; i++) snap[i] = data[i];
         if (exp_q.size() == 0) begin
            chk("read_unexpected", 1, 0);
         end else begin
            mon_e   = exp_q.pop_front();
            mon_bad = 0;
            for (int i = 0; i < DEPTH; i++) begin
               if (int'(data[i]) != val(mon_e.kind, mon_e.n0 + i)) mon_bad++;
            end
            chk("frame_d0", int'(data[0]), mon_e.a0);
            chk("frame_dpre", int'(data[PRETRIG]), mon_e.apre);
            chk("frame_dlast", int'(data[DEPTH-1]), mon_e.alast);
            chk("frame_mismatch_cnt", mon_bad, 0);
            if (mon_e.kind == KSine) begin
               chk("sine_trig_le_level", int'(data[PRETRIG] <= 12'd2048), 1);
               chk("sine_prev_gt_level", int'(data[PRETRIG-1] > 12'd2048), 1);
            end
         end
      end
   end

   task automatic start_arm();
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
   endtask

   task automatic feed(input int kind, input int n, input bit toggle);
      int v  = 0;
      bit ph = 1'b0;
      while (v < n) begin
         if (toggle && ph) begin
            sample_valid = 1'b0;
            sample       = 12'hABC;
         end else begin
            sample_valid = 1'b1;
            sample       = WIDTH'(val(kind, v));
         end
         @(posedge clk); #1;
         if (sample_valid && kind == KRamp) begin
            if (v == 299) chk("trig_before_level", int'(triggered), 0);
            if (v == 300) chk("trig_on_level", int'(triggered), 1);
         end
         if (sample_valid) v++;
         ph = ~ph;
      end
      sample_valid = 1'b0;
   endtask

   // Copier model: waits for read, drops ready for low cycles, then restores it.
   task automatic finish_copy(input int c0, input int low, input string tag);
      int t   = 0;
      int bad = 0;
      int nb  = 0;
      while (read_cnt == c0 && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      if (read_cnt == c0) begin
         chk({tag, "_read_timeout"}, 0, 1);
         return;
      end
      chk({tag, "_one_read"}, read_cnt, c0 + 1);
      ready = 1'b0;
      repeat (low) begin
         @(posedge clk); #1;
         if (!busy || read_o) nb++;
      end
      chk({tag, "_busy_during_copy"}, nb, 0);
      ready = 1'b1;
      chk({tag, "_busy_at_ready"}, int'(busy), 1);
      @(posedge clk); #1;
      chk({tag, "_busy_after_ready"}, int'(busy), 0);
      chk({tag, "_trig_cleared"}, int'(triggered), 0);
      for (int i = 0; i < DEPTH; i++) if (data[i] !== snap[i]) bad++;
      chk({tag, "_data_stable"}, bad, 0);
      chk({tag, "_read_total"}, read_cnt, c0 + 1);
   endtask

   initial begin
      int c0;
      int nb;
      rst          = 1'b1;
      sample       = '0;
      sample_valid = 1'b0;
      trig_level   = 12'd300;
      trig_slope   = 1'b1;
      arm          = 1'b0;
      ready        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_triggered", int'(triggered), 0);
      chk("rst_read", int'(read_o), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Ramp, rising at 300.
      c0 = read_cnt;
      push_exp(KRamp, 236, 236, 300, 491);
      start_arm();
      feed(KRamp, 492, 1'b0);
      finish_copy(c0, 3, "ramp");

      // Copier busy at end of POST: read must wait for ready.
      c0    = read_cnt;
      ready = 1'b0;
      push_exp(KRamp, 236, 236, 300, 491);
      start_arm();
      feed(KRamp, 492, 1'b0);
      nb = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (!busy) nb++;
      end
      chk("hold_no_read", read_cnt, c0);
      chk("hold_busy", nb, 0);
      ready = 1'b1;
      finish_copy(c0, 3, "hold");

      // Long copy of 258 cycles.
      c0 = read_cnt;
      push_exp(KRamp, 236, 236, 300, 491);
      start_arm();
      feed(KRamp, 492, 1'b0);
      finish_copy(c0, 258, "longcopy");

      // Falling edge on a sine at mid-scale.
      c0         = read_cnt;
      trig_level = 12'd2048;
      trig_slope = 1'b0;
      push_exp(KSine, 86, sinv(86), sinv(150), sinv(341));
      start_arm();
      feed(KSine, 342, 1'b0);
      finish_copy(c0, 3, "sine");

      // Ramp with sample_valid toggling every cycle.
      c0         = read_cnt;
      trig_level = 12'd300;
      trig_slope = 1'b1;
      push_exp(KRamp, 236, 236, 300, 491);
      start_arm();
      feed(KRamp, 492, 1'b1);
      finish_copy(c0, 3, "gappy");

      // Reset 10 samples into POST, then a clean capture.
      c0 = read_cnt;
      start_arm();
      feed(KRamp, 311, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_triggered", int'(triggered), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_read", read_cnt, c0);
      push_exp(KRamp, 236, 236, 300, 491);
      start_arm();
      feed(KRamp, 492, 1'b0);
      finish_copy(c0, 3, "after_abort");
      chk("exp_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
